// File: rtl/dma_inject.sv
// DMA data injector: splices a DMA MM2S stream into one of num in-line AXIS channels
// for a programmed beat count, switching only at a packet boundary of that channel.
module dma_inject #(
    parameter int width   = 32,
    parameter int num     = 8,
    parameter int timeout = 1000
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   en,
    input  logic [2:0]             sel,
    input  logic [16:0]            size,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [16:0]            data_num,
    input  logic [width-1:0]       inject_axis_tdata,
    input  logic [width/8-1:0]     inject_axis_tkeep,
    input  logic                   inject_axis_tvalid,
    input  logic                   inject_axis_tlast,
    output logic                   inject_axis_tready,
    input  logic [num*width-1:0]   s_axis_tdata,
    input  logic [num*width/8-1:0] s_axis_tkeep,
    input  logic [num-1:0]         s_axis_tvalid,
    input  logic [num-1:0]         s_axis_tlast,
    output logic [num-1:0]         s_axis_tready,
    output logic [num*width-1:0]   m_axis_tdata,
    output logic [num*width/8-1:0] m_axis_tkeep,
    output logic [num-1:0]         m_axis_tvalid,
    output logic [num-1:0]         m_axis_tlast,
    input  logic [num-1:0]         m_axis_tready
);
    localparam int kw = width / 8;
    localparam int tw = (timeout > 1) ? $clog2(timeout) : 1;

    typedef enum logic [1:0] {IDLE, ALIGN, INJECT, DONE} state_t;

    state_t        state, state_nxt;
    logic          en_q;
    logic [2:0]    sel_l;
    logic [16:0]   size_l;
    logic [tw-1:0] idle_cnt;
    logic [num-1:0] pkt_open;
    logic          arm, inj_acc, inj_last, inj_expire;
    logic          unused_tlast;

    // The source stream's own framing is discarded; the run length defines tlast.
    assign unused_tlast = inject_axis_tlast;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        m_axis_tdata       = s_axis_tdata;
        m_axis_tkeep       = s_axis_tkeep;
        m_axis_tvalid      = s_axis_tvalid;
        m_axis_tlast       = s_axis_tlast;
        s_axis_tready      = m_axis_tready;
        inject_axis_tready = 1'b0;
        busy               = (state != IDLE);
        done               = (state == DONE);
        state_nxt          = state;
        arm                = 1'b0;
        inj_acc            = 1'b0;
        inj_last           = 1'b0;
        inj_expire         = 1'b0;
        case (state)
            IDLE: begin
                arm = en && !en_q && (size != '0) && (int'(sel) < num);
                if (arm) state_nxt = ALIGN;
            end
            ALIGN: begin
                // One blanked cycle at the boundary so no source beat slips in before the swap.
                if (!pkt_open[sel_l]) begin
                    s_axis_tready[sel_l] = 1'b0;
                    m_axis_tvalid[sel_l] = 1'b0;
                    state_nxt            = INJECT;
                end
            end
            INJECT: begin
                inj_last                               = (data_num == size_l - 17'd1);
                m_axis_tdata[int'(sel_l)*width +: width] = inject_axis_tdata;
                m_axis_tkeep[int'(sel_l)*kw +: kw]     = inject_axis_tkeep;
                m_axis_tvalid[sel_l]                   = inject_axis_tvalid;
                m_axis_tlast[sel_l]                    = inj_last;
                s_axis_tready[sel_l]                   = 1'b0;
                inject_axis_tready                     = m_axis_tready[sel_l];
                inj_acc    = inject_axis_tvalid && m_axis_tready[sel_l];
                inj_expire = !inj_acc && (idle_cnt == tw'(timeout - 1));
                if ((inj_acc && inj_last) || inj_expire) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            en_q      <= 1'b0;
            sel_l     <= '0;
            size_l    <= '0;
            idle_cnt  <= '0;
            pkt_open  <= '0;
            data_num  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == IDLE) en_q <= en;
            for (int unsigned i = 0; i < num; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) pkt_open[i] <= !s_axis_tlast[i];
            end
            if (arm) begin
                sel_l     <= sel;
                size_l    <= size;
                data_num  <= '0;
                timed_out <= 1'b0;
                idle_cnt  <= '0;
            end
            if (inj_acc) begin
                data_num <= data_num + 17'd1;
                idle_cnt <= '0;
            end else if (inj_expire) begin
                timed_out <= 1'b1;
            end else if (state == INJECT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule
